// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR/PASS with tag sideband.
// Mux levels are spread over PIPE_STAGES registers under one global advance.
module shift_pipe #(
   parameter  int WIDTH       = 32,
   parameter  int PIPE_STAGES = 2,
   parameter  int TAG_W       = 4,
   localparam int SHW         = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } op_e;

   function automatic logic [WIDTH-1:0] shift_f(
      input logic [WIDTH-1:0] x,
      input logic [2:0]       op,
      input int               k
   );
      logic [WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = x << k;
         OP_SRL:  r = x >> k;
         OP_SRA:  r = $unsigned($signed(x) >>> k);
         OP_ROL:  r = (x << k) | (x >> (WIDTH - k));
         OP_ROR:  r = (x >> k) | (x << (WIDTH - k));
         default: r = x;
      endcase
      return r;
   endfunction

   logic             adv;
   logic             valid_q [PIPE_STAGES];
   logic [WIDTH-1:0] data_q  [PIPE_STAGES];
   logic [WIDTH-1:0] data_d  [PIPE_STAGES];
   logic [TAG_W-1:0] tag_q   [PIPE_STAGES];
   logic [WIDTH-1:0] din     [PIPE_STAGES];
   logic [2:0]       op_s    [PIPE_STAGES];
   logic [SHW-1:0]   amt_s   [PIPE_STAGES];
   logic [WIDTH-1:0] lvl     [SHW];

   assign adv        = !valid_q[PIPE_STAGES-1] || out_ready;
   assign in_ready   = adv;
   assign out_valid  = valid_q[PIPE_STAGES-1];
   assign out_result = data_q[PIPE_STAGES-1];
   assign out_tag    = tag_q[PIPE_STAGES-1];

   assign din[0]   = in_a;
   assign op_s[0]  = in_op;
   assign amt_s[0] = in_amt;

   // op/amt registers feed the levels of the following stage
   for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_ctl
      logic [2:0]     op_q;
      logic [SHW-1:0] amt_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            op_q  <= '0;
            amt_q <= '0;
         end else if (adv) begin
            op_q  <= op_s[s-1];
            amt_q <= amt_s[s-1];
         end
      end

      assign op_s[s]  = op_q;
      assign amt_s[s] = amt_q;
      assign din[s]   = data_q[s-1];
   end

   for (genvar i = 0; i < SHW; i++) begin : g_lvl
      localparam int S     = (i * PIPE_STAGES) / SHW;
      localparam bit FIRST = (i == 0) ||
                             ((((i - 1) * PIPE_STAGES) / SHW) != S);
      localparam bit LAST  = (i == SHW - 1) ||
                             ((((i + 1) * PIPE_STAGES) / SHW) != S);
      logic [WIDTH-1:0] src;

      if (FIRST) begin : g_first
         assign src = din[S];
      end else begin : g_chain
         assign src = lvl[i-1];
      end

      assign lvl[i] = amt_s[S][i] ? shift_f(src, op_s[S], 2 ** i) : src;

      if (LAST) begin : g_last
         assign data_d[S] = lvl[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < PIPE_STAGES; s++) begin
            valid_q[s] <= 1'b0;
            data_q[s]  <= '0;
            tag_q[s]   <= '0;
         end
      end else if (adv) begin
         valid_q[0] <= in_valid && in_ready;
         data_q[0]  <= data_d[0];
         tag_q[0]   <= in_tag;
         for (int s = 1; s < PIPE_STAGES; s++) begin
            valid_q[s] <= valid_q[s-1];
            data_q[s]  <= data_d[s];
            tag_q[s]   <= tag_q[s-1];
         end
      end
   end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: four configurations fed from one stimulus bus,
// each scored against a mask-arithmetic shift model and a latency model.
module tb_shift_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_a = '0;
   logic [4:0]  in_amt = '0;
   logic [2:0]  in_op = '0;
   logic [3:0]  in_tag = '0;

   logic        ir  [4];
   logic        ov  [4];
   logic [31:0] res [4];
   logic [3:0]  tg  [4];
   logic [7:0]  res3;

   always #5 clk = ~clk;

   shift_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .in_a(in_a), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[0]), .out_ready(out_ready),
      .out_result(res[0]), .out_tag(tg[0]));

   shift_pipe #(.WIDTH(32), .PIPE_STAGES(1), .TAG_W(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .in_a(in_a), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[1]), .out_ready(out_ready),
      .out_result(res[1]), .out_tag(tg[1]));

   shift_pipe #(.WIDTH(32), .PIPE_STAGES(5), .TAG_W(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
      .in_a(in_a), .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[2]), .out_ready(out_ready),
      .out_result(res[2]), .out_tag(tg[2]));

   shift_pipe #(.WIDTH(8), .PIPE_STAGES(3), .TAG_W(4)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
      .in_a(in_a[7:0]), .in_amt(in_amt[2:0]), .in_op(in_op), .in_tag(in_tag),
      .out_valid(ov[3]), .out_ready(out_ready),
      .out_result(res3), .out_tag(tg[3]));

   assign res[3] = {24'b0, res3};

   function automatic int pw(input int k);
      return (k == 3) ? 8 : 32;
   endfunction

   function automatic int ps(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         2:       return 5;
         default: return 3;
      endcase
   endfunction

   // Shift of a w-bit value done on a 64-bit canvas with masks
   function automatic logic [31:0] ref_f(
      input logic [31:0] a, input int w, input logic [2:0] op, input int n);
      logic [63:0] m, x, r;
      m = (64'd1 << w) - 64'd1;
      x = {32'b0, a} & m;
      case (op)
         3'd0: r = x << n;
         3'd1: r = x >> n;
         3'd2: begin
            r = x >> n;
            if (x[w-1]) r = r | (m & ~(m >> n));
         end
         3'd3: r = (x << n) | (x >> (w - n));
         3'd4: r = (x >> n) | (x << (w - n));
         default: r = x;
      endcase
      r = r & m;
      return r[31:0];
   endfunction

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [31:0] e_res  [4][1024];
   logic [3:0]  e_tag  [4][1024];
   int          e_acc  [4][1024];
   int          e_snap [4][1024];
   int          wp [4];
   int          rp [4];
   int          stalls [4];
   bit          fresh [4];
   int          cyc = 0;
   bit          prev_rst = 1'b0;
   bit          lit_en = 1'b0;
   logic [31:0] lit_val = '0;

   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 4; k++) begin
         if (prev_rst) begin
            chk($sformatf("rst_valid[%0d]", k), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_ready[%0d]", k), 64'(ir[k]), 64'd1);
            chk($sformatf("rst_result[%0d]", k), 64'(res[k]), 64'd0);
            chk($sformatf("rst_tag[%0d]", k), 64'(tg[k]), 64'd0);
         end
         if (rst) begin
            wp[k]     = 0;
            rp[k]     = 0;
            stalls[k] = 0;
            fresh[k]  = 1'b1;
         end else begin
            chk($sformatf("in_ready[%0d]", k), 64'(ir[k]),
                64'(!ov[k] || out_ready));
            if (ov[k]) begin
               if (wp[k] == rp[k]) begin
                  nvec++;
                  nerr++;
                  $display("FAIL stale[%0d]: got result %0h with none expected",
                           k, res[k]);
               end else begin
                  int h;
                  h = rp[k] % 1024;
                  chk($sformatf("result[%0d]", k), 64'(res[k]), 64'(e_res[k][h]));
                  chk($sformatf("tag[%0d]", k), 64'(tg[k]), 64'(e_tag[k][h]));
                  if (fresh[k])
                     chk($sformatf("latency[%0d]", k), 64'(cyc - e_acc[k][h]),
                         64'(ps(k) + stalls[k] - e_snap[k][h]));
               end
            end
            if (ov[k] && out_ready && wp[k] != rp[k]) rp[k]++;
            fresh[k] = !ov[k] || out_ready;
            if (ov[k] && !out_ready) stalls[k]++;
            if (in_valid && ir[k]) begin
               int w, t;
               logic [31:0] e;
               w = pw(k);
               e = ref_f(in_a, w, in_op, int'(in_amt) & (w - 1));
               if (lit_en && k == 0) chk("model_pin", 64'(e), 64'(lit_val));
               if (lit_en && w == 32) e = lit_val;
               t = wp[k] % 1024;
               e_res[k][t]  = e;
               e_tag[k][t]  = in_tag;
               e_acc[k][t]  = cyc;
               e_snap[k][t] = stalls[k];
               wp[k]++;
            end
         end
      end
      prev_rst = rst;
   end

   task automatic beat(input logic v, input logic [31:0] a,
                       input logic [4:0] amt, input logic [2:0] op,
                       input logic [3:0] tag, input logic rdy);
      in_valid  = v;
      in_a      = a;
      in_amt    = amt;
      in_op     = op;
      in_tag    = tag;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, '0, '0, '0, '0, 1'b1);
   endtask

   logic [2:0]  d_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd2, 3'd4};
   logic [4:0]  d_amt [8] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd31, 5'd31};
   logic [31:0] d_lit [8] = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F,
                              32'h0000_0F18, 32'h1800_000F, 32'h8000_00F1,
                              32'hFFFF_FFFF, 32'h0000_01E3};

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         lit_en  = 1'b1;
         lit_val = d_lit[i];
         beat(1'b1, 32'h8000_00F1, d_amt[i], d_op[i], 4'd3, 1'b1);
      end
      lit_en = 1'b0;
      idle(8);

      for (int i = 0; i < 16; i++)
         beat(1'b1, $urandom, 5'($urandom), 3'($urandom), 4'(i), 1'b1);
      idle(8);

      for (int i = 0; i < 20; i++)
         beat(1'b1, $urandom, 5'($urandom), 3'($urandom), 4'(i),
              !(i >= 6 && i < 11));
      idle(8);

      beat(1'b1, $urandom, 5'd3, 3'd0, 4'hA, 1'b1);
      beat(1'b1, $urandom, 5'd5, 3'd3, 4'hB, 1'b1);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(10);

      for (int i = 0; i < 2000; i++) begin
         logic [4:0] amt;
         amt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         beat($urandom_range(0, 3) != 0, $urandom, amt, 3'($urandom),
              4'($urandom), $urandom_range(0, 9) < 7);
      end
      idle(12);
      @(negedge clk);
      for (int k = 0; k < 4; k++)
         chk($sformatf("drained[%0d]", k), 64'(wp[k] - rp[k]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
